spi_master: RTL and testbench

- Byte-oriented SPI master (initiator). Drives SCLK, MOSI and SS, and samples MISO.
- Lets the CPU/AXI-Lite side talk to the team's SPI slave peripheral and its register file.
- One 8-bit full-duplex transfer per start request, MSB first, with CPOL/CPHA selectable per transfer.
- A command/addressing layer, if needed, sits above this block and issues consecutive bytes.

---
 rtl/spi_master.sv | 111 +++++++++++
 tb/tb_spi_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide SPI master with per-transfer CPOL/CPHA, MSB first
module spi_master #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       ready,
    output logic       done,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CP0,
        CP1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          cpol_l;
    logic          cpha_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            cpol_l  <= 1'b0;
            cpha_l  <= 1'b0;
            rx_data <= 8'h00;
            ready   <= 1'b1;
            done    <= 1'b0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            SS      <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Idle clock level follows the live cpol so the bus is parked before SS falls
                    SCLK  <= cpol;
                    MOSI  <= 1'b0;
                    SS    <= 1'b1;
                    ready <= 1'b1;
                    if (start) begin
                        tx_sr   <= tx_data;
                        cpol_l  <= cpol;
                        cpha_l  <= cpha;
                        cnt     <= '0;
                        bit_cnt <= 3'd0;
                        ready   <= 1'b0;
                        SS      <= 1'b0;
                        MOSI    <= tx_data[7];
                        SCLK    <= cpol ^ cpha;
                        state   <= CP0;
                    end
                end
                CP0: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        rx_sr <= {rx_sr[6:0], MISO};
                        SCLK  <= cpol_l ^ ~cpha_l;
                        state <= CP1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CP1: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state   <= IDLE;
                            rx_data <= rx_sr;
                            done    <= 1'b1;
                            SS      <= 1'b1;
                            SCLK    <= cpol_l;
                            MOSI    <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            MOSI    <= tx_sr[6];
                            SCLK    <= cpol_l ^ cpha_l;
                            state   <= CP0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpol, cpha, start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       ready, done, SCLK, MOSI, MISO, SS;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    // behavioural slave state
    logic       m_pol = 1'b0, m_pha = 1'b0, loopback = 1'b0;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    logic       s_miso = 1'b0;
    int         s_cnt = 0;

    spi_master #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .start(start),
        .tx_data(tx_data), .rx_data(rx_data), .ready(ready), .done(done),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    assign MISO = loopback ? MOSI : s_miso;

    always @(negedge SS) begin
        s_cnt  = 0;
        s_rx   = 8'h00;
        s_miso = s_tx[7];
    end

    // slave samples on rising SCLK when cpol==cpha, falling otherwise; presents next bit afterwards
    always @(SCLK) begin
        if (SS === 1'b0 && SCLK === (m_pol == m_pha) && s_cnt < 8) begin
            s_rx = {s_rx[6:0], MOSI};
            s_cnt++;
            if (s_cnt < 8) s_miso = s_tx[7 - s_cnt];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input string p, input logic [7:0] tx, input logic pol,
                            input logic pha, input logic lb, input logic [7:0] resp);
        int acc, ssl, n;
        m_pol = pol; m_pha = pha; loopback = lb; s_tx = resp;
        @(negedge clk);
        cpol = pol; cpha = pha; tx_data = tx;
        @(negedge clk);
        check({p, "_idle_sclk"}, 32'(SCLK), 32'(pol));
        check({p, "_ready"}, 32'(ready), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tx_data = ~tx;
        acc = cyc;
        check({p, "_first_sclk"}, 32'(SCLK), 32'(pol ^ pha));
        ssl = 0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (SS === 1'b0) ssl++;
            @(negedge clk);
            n++;
        end
        check({p, "_done_seen"}, 32'(n < 200), 32'd1);
        check({p, "_latency"}, 32'(cyc - acc), 32'(16 * D));
        check({p, "_ss_low"}, 32'(ssl), 32'(16 * D));
        check({p, "_rx"}, 32'(rx_data), 32'(lb ? tx : resp));
        check({p, "_slave_rx"}, 32'(s_rx), 32'(tx));
        check({p, "_end_sclk"}, 32'(SCLK), 32'(pol));
        @(negedge clk);
        check({p, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0, d1, d2, n, ssh;
        logic mosi_or;
        reset = 1'b1; cpol = 1'b1; cpha = 1'b0; start = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ss", 32'(SS), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_sclk_live", 32'(SCLK), 32'd1);
        cpol = 1'b0;

        run_xfer("m0", 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00);
        run_xfer("m3", 8'hC3, 1'b1, 1'b1, 1'b0, 8'h3C);
        run_xfer("m1", 8'h81, 1'b0, 1'b1, 1'b0, 8'h7E);
        run_xfer("m2", 8'h81, 1'b1, 1'b0, 1'b0, 8'h7E);

        // start pulsed mid-transfer must be ignored
        m_pol = 1'b0; m_pha = 1'b0; loopback = 1'b0; s_tx = 8'h5A;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        mosi_or = 1'b0;
        repeat (10) begin @(negedge clk); mosi_or |= MOSI; end
        tx_data = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin @(negedge clk); mosi_or |= MOSI; end
        check("ign_mosi", 32'(mosi_or), 32'd0);
        check("ign_dones", 32'(done_cnt - d0), 32'd1);
        check("ign_rx", 32'(rx_data), 32'h5A);
        check("ign_ss_idle", 32'(SS), 32'd1);

        // back-to-back with start held high
        loopback = 1'b1;
        @(negedge clk);
        tx_data = 8'h12; start = 1'b1;
        @(negedge clk);
        tx_data = 8'h34;
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        d1 = cyc;
        check("b2b_rx1", 32'(rx_data), 32'h12);
        ssh = 0;
        n = 0;
        while (SS !== 1'b0 && n < 10) begin ssh++; @(negedge clk); n++; end
        start = 1'b0;
        check("b2b_ss_high", 32'(ssh), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        d2 = cyc;
        check("b2b_gap", 32'(d2 - d1), 32'(16 * D + 1));
        check("b2b_rx2", 32'(rx_data), 32'h34);

        // reset during bit 4 aborts without done
        @(negedge clk);
        tx_data = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_ss_low", 32'(SS), 32'd0);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("abort_ss", 32'(SS), 32'd1);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_sclk", 32'(SCLK), 32'd0);
        check("abort_rx", 32'(rx_data), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_xfer("post", 8'h96, 1'b0, 1'b0, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
